// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, handshake levels and operand helpers for the divider.
`default_nettype none

package div_pkg;

  localparam int REG_W     = 32;
  localparam int DREG_W    = 64;
  localparam int DIV_ITERS = 32;

  localparam logic DIV_START       = 1'b1;
  localparam logic DIV_STOP        = 1'b0;
  localparam logic DIV_READY       = 1'b1;
  localparam logic DIV_NOT_READY   = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  function automatic logic [REG_W-1:0] neg32(input logic [REG_W-1:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of an operand: only negative values in signed mode are flipped.
  function automatic logic [REG_W-1:0] abs_op(input logic sgn, input logic [REG_W-1:0] v);
    return (sgn && v[REG_W-1]) ? neg32(v) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div.sv
// div: 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// result_o = {remainder, quotient}; ready_o held while start_i stays high.
`default_nettype none

module div
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [REG_W-1:0]  opdata1_i,
  input  logic [REG_W-1:0]  opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [DREG_W-1:0] result_o,
  output logic              ready_o
);

  div_state_e       state_q;
  logic [5:0]       cnt_q;
  logic [64:0]      work_q;
  logic [64:0]      work_d;
  logic [32:0]      diff;
  logic [REG_W-1:0] op2_q;
  logic             neg1_q;
  logic             neg2_q;
  logic [REG_W-1:0] quo;
  logic [REG_W-1:0] rem;

  assign diff = {1'b0, work_q[63:32]} - {1'b0, op2_q};

  always_comb begin
    work_d = work_q << 1;
    if (!diff[32]) begin
      work_d = {diff[31:0], work_q[31:0], 1'b1};
    end
  end

  // Sign flags are latched already gated by the signed mode, so unsigned needs no fix-up.
  assign quo = (neg1_q ^ neg2_q) ? neg32(work_q[31:0]) : work_q[31:0];
  assign rem = neg1_q ? neg32(work_q[64:33]) : work_q[64:33];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= 6'd0;
      work_q   <= 65'd0;
      op2_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          ready_o  <= DIV_NOT_READY;
          result_o <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q <= DIV_ON;
              cnt_q   <= 6'd0;
              work_q  <= {32'd0, abs_op(signed_div_i, opdata1_i), 1'b0};
              op2_q   <= abs_op(signed_div_i, opdata2_i);
              neg1_q  <= signed_div_i & opdata1_i[REG_W-1];
              neg2_q  <= signed_div_i & opdata2_i[REG_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          result_o <= '0;
          if (annul_i) begin
            state_q <= DIV_FREE;
            ready_o <= DIV_NOT_READY;
          end else begin
            state_q <= DIV_END;
            ready_o <= DIV_READY;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state_q  <= DIV_FREE;
            ready_o  <= DIV_NOT_READY;
            result_o <= '0;
          end else if (cnt_q != 6'(DIV_ITERS)) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 6'd1;
          end else begin
            state_q  <= DIV_END;
            result_o <= {rem, quo};
            ready_o  <= DIV_READY;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state_q  <= DIV_FREE;
            ready_o  <= DIV_NOT_READY;
            result_o <= '0;
          end
        end
        default: state_q <= DIV_FREE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// tb_div: scoreboard bench for the divider; expected {rem, quo} queued at start, popped at ready.
`default_nettype none

module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operands and mode are scrambled right after the start edge to prove they are latched.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    int          lat;
    int          exp_lat;
    logic [63:0] exp;
    exp_q.push_back(model(s, a, b));
    exp_lat      = (b == 32'd0) ? 1 : 33;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~s;
    lat = 0;
    while (!ready_o && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    exp = exp_q.pop_front();
    check({tag, " result"}, result_o, exp);
    annul_i = 1'b1;
    tick();
    check({tag, " hold ready"}, 64'(ready_o), 64'd1);
    check({tag, " hold result"}, result_o, exp);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check({tag, " drop ready"}, 64'(ready_o), 64'd0);
    check({tag, " drop result"}, result_o, 64'd0);
  endtask

  initial begin
    int highs;
    int n;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div(1'b0, 32'd100, 32'd7, "u100/7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "s-7/2");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "uFFFFFFFF/1");
    run_div(1'b0, 32'd5, 32'd0, "u5/0");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "smin/-1");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "s7/-2");
    run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, "s-100/-7");
    run_div(1'b0, 32'h8000_0000, 32'd3, "u80000000/3");
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      run_div(1'(i & 1), a, b, $sformatf("rand%0d", i));
    end

    // Annul at iteration 10 must never produce a ready pulse.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul result", result_o, 64'd0);
    annul_i = 1'b0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) highs++;
    end
    check("annul no pulse", 64'(highs), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, "post-annul 9/3");

    // Asynchronous reset at iteration 20, observed before the next clock edge.
    signed_div_i = 1'b1;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    #1 rst = 1'b1;
    #1;
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    start_i = 1'b0;
    #1 rst = 1'b0;
    tick();
    run_div(1'b0, 32'd9, 32'd3, "post-rst 9/3");

    // Reset while a finished result is being held.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    n = 0;
    tick();
    while (!ready_o && n < 40) begin
      tick();
      n++;
    end
    check("endrst before", result_o, {32'd2, 32'd14});
    #1 rst = 1'b1;
    #1;
    check("endrst ready", 64'(ready_o), 64'd0);
    check("endrst result", result_o, 64'd0);
    start_i = 1'b0;
    #1 rst = 1'b0;
    tick();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "post-endrst -7/2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and rst, and rst == `RstEnable SHALL mean reset asserted.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port rst, input, 1, asynchronous active-high reset.
REQ-004 Port signed_div_i, input, 1: 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-005 Port opdata1_i, input, `RegBus (32), dividend.
REQ-006 Port opdata2_i, input, `RegBus (32), divisor.
REQ-007 Port start_i, input, 1, `DivStart/`DivStop, request from ex; held high until ready_o is seen.
REQ-008 Port annul_i, input, 1: 1 = cancel the division in progress (flush/exception).
REQ-009 Port result_o, output reg, `DoubleRegBus (64): [63:32] remainder (HI), [31:0] quotient (LO).
REQ-010 Port ready_o, output reg, 1, `DivResultReady/`DivResultNotReady.

Function
REQ-011 The FSM SHALL have four states: FREE, BYZERO, ON, END.
REQ-012 In FREE with start_i=1 and annul_i=0: opdata2_i==0 SHALL go to BYZERO; otherwise the block SHALL go to ON, clear the 6-bit counter, and latch the operands, mode and operand signs.
REQ-013 When signed_div_i=1, each negative operand SHALL be replaced by its two's complement before iteration; later changes to the inputs SHALL be ignored.
REQ-014 In FREE with start_i=0 or annul_i=1, the FSM SHALL stay in FREE, with ready_o=0 and result_o=0.
REQ-015 BYZERO SHALL go to END on the next edge with a zero result; annul_i=1 in BYZERO SHALL go to FREE instead.
REQ-016 Each ON cycle with counter<32 SHALL perform one restoring step on a 65-bit working register (initial value {32'b0, |op1|, 1'b0}):
 - diff = {1'b0, work[63:32]} - {1'b0, |op2|}.
 - If diff[32]=1: work <= work<<1.
 - Else: work <= {diff[31:0], work[31:0], 1'b1}.
 - counter increments.
REQ-017 In ON with counter==32, signed mode, the quotient SHALL be negated iff the dividend and divisor signs differ, and the remainder SHALL be negated iff the dividend is negative.
REQ-018 The counter==32 cycle SHALL also load result_o = {remainder, quotient}, set ready_o=1 and go to END.
REQ-019 Unsigned mode SHALL apply no negation.
REQ-020 Latency SHALL be as follows:
 - Nonzero divisor, start sampled at edge N: ready_o=1 after edge N+33.
 - Zero divisor: ready_o=1 after edge N+1, result 0.
REQ-021 annul_i=1 in ON SHALL return to FREE on the next edge with ready_o=0 and result_o=0; ready_o SHALL never pulse for an annulled division.
REQ-022 In END with start_i=1, the block SHALL hold ready_o=1 and result_o stable, and SHALL ignore annul_i.
REQ-023 In END with start_i=0, the next edge SHALL go to FREE and clear ready_o and result_o.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-025 A new start SHALL be accepted only from FREE, so back-to-back divisions need at least one start_i=0 cycle.

Reset
REQ-026 Asserting rst SHALL immediately force state=FREE, counter=0, working register=0, ready_o=0 and result_o=0, including in the middle of a division.
REQ-027 After rst deasserts, the first start SHALL obey REQ-012.

Structure
REQ-028 The state encodings (`DivFree, `DivByZero, `DivOn, `DivEnd), `DivStart/`DivStop, `DivResultReady/`DivResultNotReady and `DoubleRegBus SHALL live in the shared defines.v.
REQ-029 The block SHALL be a single module with no sub-module; ex SHALL raise stallreq_o while start_i=1 and ready_o=0.

Verification
REQ-030 Unsigned 100/7: start held -> after 33 edges, ready_o=1 and result_o={32'd2, 32'd14}.
REQ-031 Signed -7/2: -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; unsigned 0xFFFFFFFF/1 -> {32'h0, 32'hFFFFFFFF}.
REQ-032 Divide by zero (5/0): -> ready_o=1 after 1 edge, result_o=0; dropping start_i -> FREE, ready_o=0.
REQ-033 Signed 0x80000000/0xFFFFFFFF: -> {32'h0, 32'h80000000}.
REQ-034 Annul: annul_i at iteration 10 -> FREE next edge; ready_o stays 0 for 40 cycles while start_i=0; a new 9/3 start then gives {0, 3}.
REQ-035 rst mid-division (iteration 20): -> all outputs 0 immediately without waiting for clk; operand changes during ON do not affect the result.
